// File: rtl/bp_btb_pkg.sv
// Shared branch-predictor types, sizing constants and the 2-bit saturating counter rule.
package bp_btb_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned BTB_ENTRIES  = 16;
  localparam int unsigned BTB_IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int unsigned BTB_TAG_BITS = XLEN - BTB_IDX_BITS - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [XLEN-1:0]         target;
    bp_ctr_e                 ctr;
  } btb_entry_t;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'(ST)) res = 2'(ctr + 2'd1);
    end else begin
      if (ctr != 2'(SNT)) res = 2'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_btb_sat_ctr.sv
// 2-bit saturating counter next-state logic; reusable by other direction predictors.
module bp_sat_ctr
  import bp_btb_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_next_c
);

  always_comb begin
    o_next_c = ctr_next(i_ctr, i_taken);
  end

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped tagged BTB with bimodal counters: zero-latency lookup, registered update.
// Optional perf counters enabled by defining BTB_PERF_EN.
module bp_btb
  import bp_btb_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_mispredict,
`ifdef BTB_PERF_EN
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_hits,
  output logic [31:0]     perf_mispredicts,
`endif
  input  logic            flush
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] w_lu_idx;
  logic [TAG_BITS-1:0] w_lu_tag;
  logic [IDX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0] w_up_tag;
  logic                w_lu_hit;
  logic                w_up_hit;
  logic [1:0]          w_ctr_next;
  logic [3:0]          w_unused_pc_lsbs;

  assign w_lu_idx = lookup_pc[IDX_BITS+1:2];
  assign w_lu_tag = lookup_pc[XLEN-1:IDX_BITS+2];
  assign w_up_idx = update_pc[IDX_BITS+1:2];
  assign w_up_tag = update_pc[XLEN-1:IDX_BITS+2];
  assign w_unused_pc_lsbs = {lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads pre-update state; a same-cycle update is not bypassed.
  assign w_lu_hit       = lookup_valid && r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);
  assign predict_taken  = w_lu_hit && r_ctr[w_lu_idx][1];
  assign predict_target = predict_taken ? r_target[w_lu_idx] : '0;

  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  bp_sat_ctr u_sat_ctr (
    .i_ctr    (r_ctr[w_up_idx]),
    .i_taken  (update_taken),
    .o_next_c (w_ctr_next)
  );

  // Priority: reset, then flush, then update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'(WNT);
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (update_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (update_taken) r_target[w_up_idx] <= update_target;
      end else if (update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
        r_ctr[w_up_idx]    <= 2'(WT);
      end
    end
  end

`ifdef BTB_PERF_EN
  logic [31:0] r_perf_lookups;
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_mispredicts;

  // Free-running event counters; wrap naturally and survive flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_lookups     <= '0;
      r_perf_hits        <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (lookup_valid) r_perf_lookups <= 32'(r_perf_lookups + 32'd1);
      if (w_lu_hit)     r_perf_hits    <= 32'(r_perf_hits + 32'd1);
      if (update_valid && update_mispredict)
        r_perf_mispredicts <= 32'(r_perf_mispredicts + 32'd1);
    end
  end

  assign perf_lookups     = r_perf_lookups;
  assign perf_hits        = r_perf_hits;
  assign perf_mispredicts = r_perf_mispredicts;
`else
  logic w_unused_mispredict;
  assign w_unused_mispredict = update_mispredict;
`endif

endmodule

// File: tb/tb_bp_btb.sv
// Directed self-checking bench for bp_btb (default 16 entries).
module tb_bp_btb;
  import bp_btb_pkg::*;

  logic            clk;
  logic            reset;
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            predict_taken;
  logic [XLEN-1:0] predict_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_mispredict;
  logic            flush;
`ifdef BTB_PERF_EN
  logic [31:0]     perf_lookups;
  logic [31:0]     perf_hits;
  logic [31:0]     perf_mispredicts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bp_btb dut (
    .clk               (clk),
    .reset             (reset),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .predict_taken     (predict_taken),
    .predict_target    (predict_target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
`ifdef BTB_PERF_EN
    .perf_lookups      (perf_lookups),
    .perf_hits         (perf_hits),
    .perf_mispredicts  (perf_mispredicts),
`endif
    .flush             (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_tgt);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
    chk({name, ".taken"}, 32'(predict_taken), 32'(exp_t));
    chk({name, ".target"}, predict_target, exp_tgt);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tgt;
    tick();
    update_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0; flush = 1'b0;
    tick();
    look("in_reset", 32'h100, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    look("post_reset", 32'h100, 1'b0, 32'h0);

    // Allocation: same-cycle lookup sees old state, next cycle hits.
    update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h200;
    look("same_cycle", 32'h100, 1'b0, 32'h0);
    tick();
    update_valid = 1'b0;
    look("alloc_hit", 32'h100, 1'b1, 32'h200);
    look("pc_lsbs_ignored", 32'h103, 1'b1, 32'h200);
    look("tag_msb_miss", 32'h8000_0100, 1'b0, 32'h0);
    lookup_valid = 1'b0; lookup_pc = 32'h100; #1;
    chk("lookup_invalid", 32'(predict_taken), 32'h0);

    // Counter walk from WT.
    train(32'h100, 1'b0, 32'h0);   // WNT
    look("wt_nt1", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0);   // SNT
    train(32'h100, 1'b0, 32'h0);   // SNT saturated
    look("snt_sat", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h200); // WNT
    look("snt_t1", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h250); // WT, new target
    look("wnt_t1", 32'h100, 1'b1, 32'h250);
    train(32'h100, 1'b1, 32'h200); // ST
    train(32'h100, 1'b1, 32'h200); // ST
    train(32'h100, 1'b1, 32'h200); // ST saturated
    train(32'h100, 1'b0, 32'h999); // WT, target kept
    look("st_nt1", 32'h100, 1'b1, 32'h200);

    // Not-taken miss must not allocate.
    train(32'h1_0004, 1'b0, 32'h700);
    look("nt_miss_noalloc", 32'h1_0004, 1'b0, 32'h0);

    // Aliasing at index 0.
    train(32'h140, 1'b1, 32'h300);
    look("alias_evicted", 32'h100, 1'b0, 32'h0);
    look("alias_new", 32'h140, 1'b1, 32'h300);

    // Flush beats a same-cycle update.
    train(32'h100, 1'b1, 32'h200);
    look("retrain", 32'h100, 1'b1, 32'h200);
    flush = 1'b1;
    train(32'h180, 1'b1, 32'h400);
    flush = 1'b0;
    look("flush_100", 32'h100, 1'b0, 32'h0);
    look("flush_180", 32'h180, 1'b0, 32'h0);
    train(32'h180, 1'b1, 32'h400);
    look("post_flush_alloc", 32'h180, 1'b1, 32'h400);

    // Reset mid-operation drops the in-flight update and invalidates.
    reset = 1'b1;
    train(32'h208, 1'b1, 32'h500);
    reset = 1'b0;
    look("reset_drop_upd", 32'h208, 1'b0, 32'h0);
    look("reset_clear", 32'h180, 1'b0, 32'h0);

`ifdef BTB_PERF_EN
    lookup_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    update_mispredict = 1'b1;
    train(32'h100, 1'b1, 32'h200);
    train(32'h100, 1'b1, 32'h200);
    update_mispredict = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    tick(); tick(); tick();
    lookup_pc = 32'h140;
    tick(); tick();
    lookup_valid = 1'b0;
    chk("perf_lookups", perf_lookups, 32'd5);
    chk("perf_hits", perf_hits, 32'd3);
    chk("perf_mispredicts", perf_mispredicts, 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("perf_lookups_rst", perf_lookups, 32'd0);
    chk("perf_hits_rst", perf_hits, 32'd0);
    chk("perf_mispredicts_rst", perf_mispredicts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
